// File: rtl/debounce_edge.sv
// Debouncer: two-flop synchroniser, 4-state accept FSM, registered rise/fall pulses.
// Latency DEBOUNCE_CYCLES+2 edges from first din sample to dout; no backpressure (din sampled every cycle).
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_async_n,
  input  logic rst_sync,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          s1, s2;
  logic          dout_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (rst_sync) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state <= STABLE_LOW;
      count <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (rst_sync) begin
      state <= STABLE_LOW;
      count <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // count holds the number of agreeing samples already taken; accept when this one makes it CNT_MAX
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      STABLE_LOW: begin
        if (s2) begin
          if (CNT_MAX == CW'(1)) begin
            state_nxt = STABLE_HIGH;
            count_nxt = '0;
          end else begin
            state_nxt = CHECK_HIGH;
            count_nxt = CW'(1);
          end
        end
      end
      CHECK_HIGH: begin
        if (!s2) begin
          state_nxt = STABLE_LOW;
          count_nxt = '0;
        end else if (count == CNT_MAX - CW'(1)) begin
          state_nxt = STABLE_HIGH;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          if (CNT_MAX == CW'(1)) begin
            state_nxt = STABLE_LOW;
            count_nxt = '0;
          end else begin
            state_nxt = CHECK_LOW;
            count_nxt = CW'(1);
          end
        end
      end
      CHECK_LOW: begin
        if (s2) begin
          state_nxt = STABLE_HIGH;
          count_nxt = '0;
        end else if (count == CNT_MAX - CW'(1)) begin
          state_nxt = STABLE_LOW;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        count_nxt = '0;
      end
    endcase
  end

  // dout is 1 in STABLE_HIGH and while a falling candidate is still being checked
  always_comb begin
    dout_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == CHECK_LOW);
    rise_nxt = (state_nxt == STABLE_HIGH) &&
               ((state == STABLE_LOW) || (state == CHECK_HIGH));
    fall_nxt = (state_nxt == STABLE_LOW) &&
               ((state == STABLE_HIGH) || (state == CHECK_LOW));
    busy     = (state == CHECK_HIGH) || (state == CHECK_LOW);
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: N=4 and N=1 builds against a run-length reference model.
module tb_debounce_edge;

  logic clk = 1'b0;
  logic rst_async_n, rst_sync, din;
  logic dout4, rise4, fall4, busy4;
  logic dout1, rise1, fall1, busy1;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses1 = 0;

  always #5 clk = ~clk;

  debounce_edge #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .rst_async_n(rst_async_n), .rst_sync(rst_sync), .din(din),
    .dout(dout4), .rise(rise4), .fall(fall4), .busy(busy4)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_async_n(rst_async_n), .rst_sync(rst_sync), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  // Reference: s2 is din delayed two edges; run counts consecutive samples disagreeing with dout
  typedef struct {
    logic s1;
    logic s2;
    int   run;
    logic dout;
    logic rise;
    logic fall;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.s1 = 1'b0; m.s2 = 1'b0; m.run = 0;
    m.dout = 1'b0; m.rise = 1'b0; m.fall = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic d, int n);
    mdl_t r;
    r = m;
    r.rise = 1'b0;
    r.fall = 1'b0;
    if (m.s2 != m.dout) begin
      r.run = m.run + 1;
      if (r.run == n) begin
        r.dout = m.s2;
        r.rise = m.s2;
        r.fall = !m.s2;
        r.run  = 0;
      end
    end else begin
      r.run = 0;
    end
    r.s2 = m.s1;
    r.s1 = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("dout4", 32'(dout4), 32'(m4.dout));
    chk("rise4", 32'(rise4), 32'(m4.rise));
    chk("fall4", 32'(fall4), 32'(m4.fall));
    chk("busy4", 32'(busy4), 32'(m4.run != 0));
    chk("dout1", 32'(dout1), 32'(m1.dout));
    chk("rise1", 32'(rise1), 32'(m1.rise));
    chk("fall1", 32'(fall1), 32'(m1.fall));
    chk("busy1", 32'(busy1), 32'(m1.run != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_async_n || rst_sync) begin
      m4 = mdl_reset();
      m1 = mdl_reset();
    end else begin
      m4 = mdl_step(m4, din, 4);
      m1 = mdl_step(m1, din, 1);
    end
    #1;
    if (rise1) pulses1++;
    if (fall1) pulses1++;
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int seen;
    int busy_seen;
    int p0;
    int runleft;

    rst_async_n = 1'b1;
    rst_sync    = 1'b0;
    din         = 1'b1;
    m4 = mdl_reset();
    m1 = mdl_reset();
    #1;
    rst_async_n = 1'b0;
    #1;
    compare_all();
    repeat (3) tick();
    chk("rst_cnt4", 32'(dut4.count), 32'd0);

    // power-on with din high: dout rises on the 6th edge after release
    rst_async_n = 1'b1;
    e = 0;
    seen = 0;
    while (dout4 !== 1'b1 && e < 12) begin
      tick();
      e++;
      if (rise4) seen++;
    end
    chk("pwr_lat", 32'(e), 32'd6);
    chk("pwr_rise_at_accept", 32'(rise4), 32'd1);
    tick();
    chk("pwr_rise_width", 32'(rise4), 32'd0);
    chk("pwr_rise_count", 32'(seen), 32'd1);

    // falling edge held
    repeat (2) tick();
    din = 1'b0;
    e = 0;
    seen = 0;
    while (dout4 !== 1'b0 && e < 12) begin
      tick();
      e++;
      if (rise4) seen++;
    end
    chk("fall_lat", 32'(e), 32'd6);
    chk("fall_pulse", 32'(fall4), 32'd1);
    tick();
    chk("fall_width", 32'(fall4), 32'd0);
    chk("fall_norise", 32'(seen), 32'd0);

    // bounce: three high samples only
    repeat (3) tick();
    din = 1'b1;
    seen = 0;
    busy_seen = 0;
    repeat (3) tick();
    din = 1'b0;
    repeat (6) begin
      tick();
      if (rise4) seen++;
      if (busy4) busy_seen = 1;
    end
    chk("bounce_norise", 32'(seen), 32'd0);
    chk("bounce_busy_seen", 32'(busy_seen), 32'd1);
    chk("bounce_dout", 32'(dout4), 32'd0);
    chk("bounce_busy_end", 32'(busy4), 32'd0);
    chk("bounce_cnt", 32'(dut4.count), 32'd0);

    // sync reset while in CHECK_HIGH with count=2
    repeat (2) tick();
    din = 1'b1;
    repeat (4) tick();
    chk("srst_pre_cnt", 32'(dut4.count), 32'd2);
    chk("srst_pre_busy", 32'(busy4), 32'd1);
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    chk("srst_cnt", 32'(dut4.count), 32'd0);
    chk("srst_busy", 32'(busy4), 32'd0);
    chk("srst_dout", 32'(dout4), 32'd0);

    // async reset between edges while dout=1
    repeat (10) tick();
    chk("arst_pre_dout", 32'(dout4), 32'd1);
    #2;
    rst_async_n = 1'b0;
    #1;
    m4 = mdl_reset();
    m1 = mdl_reset();
    chk("arst_dout_now", 32'(dout4), 32'd0);
    chk("arst_nofall", 32'(fall4), 32'd0);
    compare_all();
    repeat (2) tick();
    rst_async_n = 1'b1;
    repeat (10) tick();
    chk("arst_recover", 32'(dout4), 32'd1);

    // N=1 build: toggle every 4 cycles, 3-edge latency, one pulse per toggle
    p0 = pulses1;
    for (int t = 0; t < 8; t++) begin
      din = ~din;
      e = 0;
      while (dout1 !== din && e < 8) begin
        tick();
        e++;
      end
      chk("n1_lat", 32'(e), 32'd3);
      if (e < 4) repeat (4 - e) tick();
    end
    chk("n1_pulses", 32'(pulses1 - p0), 32'd8);

    // randomized bouncing with occasional resets
    runleft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (runleft == 0) begin
        din = 1'($urandom_range(0, 1));
        runleft = int'($urandom_range(1, 9));
      end
      runleft--;
      rst_sync = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_async_n = 1'b0;
        #1;
        m4 = mdl_reset();
        m1 = mdl_reset();
        compare_all();
        #1;
        rst_async_n = 1'b1;
      end
      tick();
    end
    rst_sync = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
